// File: rtl/membus_arbiter.sv
// Time-slot arbiter sharing one synchronous RAM between a CPU core and a video fetcher.
// Each slot is an address cycle followed by a data cycle; video may take at most VID_BURST slots in a row.
module membus_arbiter #(
    parameter int unsigned VID_BURST = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        locked,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_out,
    input  logic        cpu_we,
    output logic [7:0]  cpu_in,
    output logic        cpu_en,
    input  logic        vid_req,
    input  logic [15:0] vid_address,
    output logic        vid_ack,
    output logic [7:0]  vid_data,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_out,
    output logic        mem_we,
    input  logic [7:0]  mem_in
);

    typedef enum logic [1:0] {
        CPU_A = 2'd0,
        CPU_D = 2'd1,
        VID_A = 2'd2,
        VID_D = 2'd3
    } state_t;

    localparam logic [3:0] BURST_MAX = 4'(VID_BURST);

    state_t      state_q, state_d;
    logic [3:0]  burst_q, burst_d;
    logic        wr_q, wr_d;
    logic [15:0] mem_address_q, mem_address_d;
    logic [7:0]  mem_out_q, mem_out_d;
    logic [7:0]  vid_data_q, vid_data_d;
    logic        vid_ack_q, vid_ack_d;

    always_comb begin
        state_d       = state_q;
        burst_d       = burst_q;
        wr_d          = wr_q;
        mem_address_d = mem_address_q;
        mem_out_d     = mem_out_q;
        vid_data_d    = vid_data_q;
        vid_ack_d     = vid_ack_q;

        // With locked low every register simply holds its value.
        if (locked) begin
            vid_ack_d = 1'b0;
            case (state_q)
                CPU_A: state_d = CPU_D;
                VID_A: state_d = VID_D;
                default: begin
                    if (state_q == VID_D) begin
                        vid_data_d = mem_in;
                        vid_ack_d  = 1'b1;
                    end
                    // Decision point at the end of every data cycle.
                    if (vid_req && (burst_q < BURST_MAX)) begin
                        state_d       = VID_A;
                        burst_d       = burst_q + 4'd1;
                        mem_address_d = vid_address;
                        wr_d          = 1'b0;
                    end else begin
                        state_d       = CPU_A;
                        burst_d       = 4'd0;
                        mem_address_d = cpu_address;
                        mem_out_d     = cpu_out;
                        wr_d          = cpu_we;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= CPU_A;
            burst_q       <= 4'd0;
            wr_q          <= 1'b0;
            mem_address_q <= 16'h0000;
            mem_out_q     <= 8'h00;
            vid_data_q    <= 8'h00;
            vid_ack_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            burst_q       <= burst_d;
            wr_q          <= wr_d;
            mem_address_q <= mem_address_d;
            mem_out_q     <= mem_out_d;
            vid_data_q    <= vid_data_d;
            vid_ack_q     <= vid_ack_d;
        end
    end

    // Strobes are also masked by reset_n so an aborted slot never leaks a pulse.
    assign cpu_en      = reset_n && locked && (state_q == CPU_D);
    assign mem_we      = reset_n && locked && wr_q && (state_q == CPU_A);
    assign vid_ack     = reset_n && locked && vid_ack_q;
    assign vid_data    = vid_data_q;
    assign mem_address = mem_address_q;
    assign mem_out     = mem_out_q;
    assign cpu_in      = mem_in;

endmodule

// File: tb/tb_membus_arbiter.sv
// Bench for membus_arbiter: directed scenarios followed by random traffic against a slot-level model.
module tb_membus_arbiter;

    localparam int VB = 3;

    logic        clock = 1'b0;
    logic        reset_n, locked, cpu_we, vid_req;
    logic [15:0] cpu_address, vid_address;
    logic [7:0]  cpu_out;
    logic [7:0]  cpu_in, vid_data, mem_out, mem_in;
    logic        cpu_en, vid_ack, mem_we;
    logic [15:0] mem_address;

    always #5 clock = ~clock;

    membus_arbiter #(.VID_BURST(VB)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .locked      (locked),
        .cpu_address (cpu_address),
        .cpu_out     (cpu_out),
        .cpu_we      (cpu_we),
        .cpu_in      (cpu_in),
        .cpu_en      (cpu_en),
        .vid_req     (vid_req),
        .vid_address (vid_address),
        .vid_ack     (vid_ack),
        .vid_data    (vid_data),
        .mem_address (mem_address),
        .mem_out     (mem_out),
        .mem_we      (mem_we),
        .mem_in      (mem_in)
    );

    // Synchronous write-first RAM, with a poke port used only for preloading.
    logic [7:0]  ram [0:65535];
    logic        poke_en = 1'b1;
    logic [15:0] poke_addr = 16'h0;
    logic [7:0]  poke_data = 8'h0;

    always @(posedge clock) begin
        if (poke_en) begin
            ram[poke_addr] <= poke_data;
            mem_in <= 8'h00;
        end else if (mem_we) begin
            ram[mem_address] <= mem_out;
            mem_in <= mem_out;
        end else begin
            mem_in <= ram[mem_address];
        end
    end

    // Reference model: the current slot as a record plus the memory image it should see.
    logic [7:0]  ref_mem [0:65535];
    logic        m_vid = 1'b0;
    int          m_phase = 0;
    int          m_run = 0;
    logic [15:0] m_addr = 16'h0;
    logic [7:0]  m_wdata = 8'h0;
    logic        m_we = 1'b0;
    logic [7:0]  m_rdata = 8'h0;
    logic        m_ack = 1'b0;
    logic [7:0]  m_ack_data = 8'h0;

    int n_checks = 0;
    int n_pass = 0;
    int cnt_en, cnt_we, cnt_ack;
    logic obs_en, obs_we, obs_ack;
    logic [15:0] obs_addr;
    logic [7:0]  obs_out, obs_vdata, obs_cin;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic model_step();
        if (!reset_n) begin
            m_vid = 1'b0; m_phase = 0; m_run = 0;
            m_addr = 16'h0; m_wdata = 8'h0; m_we = 1'b0;
            m_ack = 1'b0; m_ack_data = 8'h0;
        end else if (locked) begin
            m_ack = 1'b0;
            if (m_phase == 0) begin
                if (!m_vid && m_we) ref_mem[m_addr] = m_wdata;
                m_rdata = ref_mem[m_addr];
                m_phase = 1;
            end else begin
                if (m_vid) begin
                    m_ack = 1'b1;
                    m_ack_data = m_rdata;
                end
                if (vid_req && m_run < VB) begin
                    m_vid = 1'b1; m_run++; m_addr = vid_address; m_we = 1'b0;
                end else begin
                    m_vid = 1'b0; m_run = 0; m_addr = cpu_address;
                    m_wdata = cpu_out; m_we = cpu_we;
                end
                m_phase = 0;
            end
        end
    endtask

    // One clock cycle with the currently driven inputs: compare, advance model, step past the edge.
    task automatic cycle();
        logic e_en, e_we, e_ack;
        @(negedge clock);
        e_en  = reset_n && locked && !m_vid && (m_phase == 1);
        e_we  = reset_n && locked && !m_vid && (m_phase == 0) && m_we;
        e_ack = reset_n && locked && m_ack;
        obs_en = cpu_en; obs_we = mem_we; obs_ack = vid_ack;
        obs_addr = mem_address; obs_out = mem_out; obs_vdata = vid_data; obs_cin = cpu_in;
        chk("cpu_en", 16'(cpu_en), 16'(e_en));
        chk("mem_we", 16'(mem_we), 16'(e_we));
        chk("vid_ack", 16'(vid_ack), 16'(e_ack));
        chk("mem_address", mem_address, m_addr);
        chk("mem_out", 16'(mem_out), 16'(m_wdata));
        chk("vid_data", 16'(vid_data), 16'(m_ack_data));
        if (e_en) chk("cpu_in", 16'(cpu_in), 16'(m_rdata));
        if (cpu_en === 1'b1) cnt_en++;
        if (mem_we === 1'b1) cnt_we++;
        if (vid_ack === 1'b1) cnt_ack++;
        model_step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [7:0] v;
        logic found;
        reset_n = 1'b0; locked = 1'b1; cpu_we = 1'b0; vid_req = 1'b0;
        cpu_address = 16'h0; vid_address = 16'h0; cpu_out = 8'h0;

        // Preload the RAM and the model image while the DUT is held in reset.
        for (int i = 0; i < 64; i++) begin
            v = 8'($urandom);
            poke_addr = 16'(i); poke_data = v; ref_mem[i] = v;
            @(posedge clock); #1;
        end
        poke_addr = 16'h0100; poke_data = 8'h3E; ref_mem[16'h0100] = 8'h3E; @(posedge clock); #1;
        poke_addr = 16'h4000; poke_data = 8'h11; ref_mem[16'h4000] = 8'h11; @(posedge clock); #1;
        poke_addr = 16'h8000; poke_data = 8'hC3; ref_mem[16'h8000] = 8'hC3; @(posedge clock); #1;
        poke_en = 1'b0;

        // Reset for exactly one modelled cycle, then the CPU-only pattern.
        cnt_en = 0; cnt_we = 0; cnt_ack = 0;
        cycle();
        reset_n = 1'b1; cpu_address = 16'h0100;
        cycle();
        chk("rst_mem_address", obs_addr, 16'h0000);
        chk("rst_cpu_en", 16'(obs_en), 16'h0);
        chk("rst_mem_we", 16'(obs_we), 16'h0);
        chk("rst_vid_ack", 16'(obs_ack), 16'h0);
        chk("rst_vid_data", 16'(obs_vdata), 16'h00);
        for (int i = 1; i < 8; i++) cycle();
        chk("cpu_only_en_count", 16'(cnt_en), 16'd4);
        chk("cpu_only_cpu_in", 16'(obs_cin), 16'h3E);

        // CPU write: request held across one decision point only.
        cnt_we = 0;
        cpu_address = 16'h4000; cpu_out = 8'h5A; cpu_we = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("wr_mem_we", 16'(obs_we), 16'h1);
        chk("wr_mem_address", obs_addr, 16'h4000);
        chk("wr_mem_out", 16'(obs_out), 16'h5A);
        cpu_we = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        chk("wr_we_count", 16'(cnt_we), 16'd1);

        // Video saturation: steady 8-cycle pattern of three video slots and one CPU slot.
        vid_req = 1'b1; vid_address = 16'h8000;
        for (int i = 0; i < 8; i++) cycle();
        cnt_en = 0; cnt_ack = 0;
        for (int i = 0; i < 8; i++) cycle();
        chk("sat_ack_count", 16'(cnt_ack), 16'd3);
        chk("sat_en_count", 16'(cnt_en), 16'd1);
        chk("sat_vid_data", 16'(obs_vdata), 16'hC3);

        // Freeze entered in a video data cycle.
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            if (m_vid && m_phase == 1) found = 1'b1;
            else cycle();
        end
        chk("freeze_found_vid_d", 16'(found), 16'h1);
        cnt_en = 0; cnt_we = 0; cnt_ack = 0;
        locked = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        chk("freeze_en_count", 16'(cnt_en), 16'd0);
        chk("freeze_we_count", 16'(cnt_we), 16'd0);
        chk("freeze_ack_count", 16'(cnt_ack), 16'd0);
        locked = 1'b1;
        cycle();
        chk("resume_no_early_ack", 16'(obs_ack), 16'h0);
        cycle();
        chk("resume_ack", 16'(obs_ack), 16'h1);
        chk("resume_vid_data", 16'(obs_vdata), 16'hC3);

        // Reset arriving in a CPU address cycle that carries a write.
        vid_req = 1'b0; cpu_address = 16'h0020; cpu_out = 8'hA7; cpu_we = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            if (!m_vid && m_phase == 0 && m_we) found = 1'b1;
            else cycle();
        end
        chk("midwr_found_cpu_a", 16'(found), 16'h1);
        reset_n = 1'b0;
        cycle();
        chk("midwr_we_in_reset", 16'(obs_we), 16'h0);
        reset_n = 1'b1; cpu_we = 1'b0;
        cycle();
        chk("midwr_we_after", 16'(obs_we), 16'h0);
        chk("midwr_addr_after", obs_addr, 16'h0000);
        cycle();
        chk("midwr_cpu_en_next", 16'(obs_en), 16'h1);

        // Random traffic over a small address window to provoke read-after-write hits.
        for (int n = 0; n < 3000; n++) begin
            reset_n = ($urandom_range(0, 99) != 0);
            locked  = ($urandom_range(0, 7) != 0);
            if (vid_req) begin
                if ($urandom_range(0, 3) == 0) vid_req = 1'b0;
            end else if ($urandom_range(0, 1) == 0) begin
                vid_req = 1'b1;
                vid_address = 16'($urandom_range(0, 63));
            end
            cpu_address = 16'($urandom_range(0, 63));
            cpu_out = 8'($urandom);
            cpu_we = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/membus_arbiter.md
MEMBUS_ARBITER -- requirements
Module: membus_arbiter

Interface
REQ-001 Parameter VID_BURST, default 3, range 1..15: maximum consecutive video slots before a forced CPU slot.
REQ-002 clock  input  1  single system clock; all registers update on its rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clock.
REQ-004 locked  input  1  PLL lock; 0 = freeze all state.
REQ-005 cpu_address  input  16  CPU core bus address.
REQ-006 cpu_out  input  8  CPU write data.
REQ-007 cpu_we  input  1  CPU write request.
REQ-008 cpu_in  output  8  read data to CPU; continuous pass-through of mem_in.
REQ-009 cpu_en  output  1  CPU clock-enable; drives the core's locked input.
REQ-010 vid_req  input  1  video fetcher requests one read; level, held until vid_ack.
REQ-011 vid_address  input  16  video read address, stable while vid_req=1.
REQ-012 vid_ack  output  1  one-cycle pulse: vid_data valid.
REQ-013 vid_data  output  8  registered video read data.
REQ-014 mem_address  output  16  registered memory address.
REQ-015 mem_out  output  8  registered memory write data.
REQ-016 mem_we  output  1  memory write strobe.
REQ-017 mem_in  input  8  memory read data; synchronous RAM, valid the cycle after mem_address is presented.

Function
REQ-018 Block SHALL implement FSM states CPU_A, CPU_D, VID_A, VID_D; every slot is an A cycle followed by a D cycle.
REQ-019 A->D transition (CPU_A->CPU_D, VID_A->VID_D) SHALL be unconditional.
REQ-020 On leaving either D state, block SHALL grant: if vid_req=1 and burst<VID_BURST -> VID_A, burst+1; else -> CPU_A, burst<=0.
REQ-021 On entering CPU_A, mem_address<=cpu_address, mem_out<=cpu_out, internal wr<=cpu_we.
REQ-022 On entering VID_A, mem_address<=vid_address; wr<=0.
REQ-023 mem_we SHALL equal wr AND (state==CPU_A) AND locked: exactly one cycle per CPU write slot, never in D or video states.
REQ-024 cpu_en SHALL be 1 only in CPU_D with locked=1; one pulse per CPU slot.
REQ-025 cpu_in SHALL equal mem_in combinationally; valid for the CPU during CPU_D.
REQ-026 At end of VID_D, vid_data<=mem_in and vid_ack<=1 for exactly the next cycle; vid_ack output gated by locked.
REQ-027 Throughput: vid_req=0 -> cpu_en every 2nd cycle; vid_req held 1 -> VID_BURST video slots then 1 CPU slot, period 2*(VID_BURST+1) cycles.
REQ-028 vid_req arriving during CPU_A/CPU_D SHALL be granted at the next decision point, latency <= 2 cycles from sample to VID_A.
REQ-029 vid_req deasserted before grant SHALL cancel it; no ack issued.
REQ-030 locked=0 SHALL hold state, burst, and all registers; cpu_en, mem_we, vid_ack forced 0; resume in same state when locked returns to 1.
REQ-031 burst SHALL be 4 bits, saturating at VID_BURST; never wraps.

Reset
REQ-032 reset_n=0 SHALL take precedence over locked and SHALL set: state CPU_A, burst 0, wr 0, mem_address 0x0000, mem_out 0x00, vid_data 0x00, vid_ack 0.
REQ-033 During reset cycle and the reset-release CPU_A cycle, cpu_en=0 and mem_we=0.
REQ-034 Reset mid-slot (any state, incl. pending write) SHALL abort the slot: no write, no ack, no cpu_en in the following cycle.

Verification
REQ-035 Reset: reset_n=0 one cycle, locked=1 -> state CPU_A, mem_address=0x0000, cpu_en=0, mem_we=0, vid_ack=0, vid_data=0x00.
REQ-036 CPU only: vid_req=0, cpu_address=0x0100, mem_in=0x3E -> cpu_en high on alternate cycles, mem_address=0x0100, cpu_in=0x3E during cpu_en.
REQ-037 CPU write: cpu_we=1, cpu_address=0x4000, cpu_out=0x5A -> mem_we=1 exactly one cycle with mem_address=0x4000, mem_out=0x5A; no repeat while cpu_we drops after cpu_en.
REQ-038 Video saturation: VID_BURST=3, vid_req=1, vid_address=0x8000, mem_in=0xC3 -> per 8 cycles 3 vid_ack pulses with vid_data=0xC3 and 1 cpu_en pulse.
REQ-039 Freeze: locked=0 for 5 cycles entered in VID_D -> no cpu_en/mem_we/vid_ack; on locked=1 VID_D completes, vid_ack next cycle.
REQ-040 Reset mid-write: reset_n=0 in CPU_A with wr=1 -> mem_we=0 in next cycle, state CPU_A, burst 0.
